v_serial_to_parallel_16: RTL and testbench

V_SERIAL_TO_PARALLEL_16 -- requirements
Module: v_serial_to_parallel_16

---
 rtl/v_serial_to_parallel_16_if.sv | 14 +
 rtl/v_serial_to_parallel_16.sv | 107 ++++++++++
 tb/tb_v_serial_to_parallel_16.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/v_serial_to_parallel_16_if.sv
// Serial-in / parallel-out handshake bundle for v_serial_to_parallel_16.
// master: serial source plus downstream consumer; slave: the collector.
interface v_serial_to_parallel_16_if;
  logic        SI;
  logic        SV;
  logic        SOF;
  logic        QR;
  logic [15:0] Q;
  logic        QV;
  logic        OVR;

  modport master (output SI, SV, SOF, QR, input Q, QV, OVR);
  modport slave  (input SI, SV, SOF, QR, output Q, QV, OVR);
endinterface

// File: rtl/v_serial_to_parallel_16.sv
// 16-bit serial-to-parallel collector with SOF framing, single-word output
// holding register, valid/ready handshake and sticky overrun flag.
module v_serial_to_parallel_16 #(
  parameter int          MSB_FIRST = 1,
  parameter logic [15:0] INIT      = 16'hFEDC
) (
  input logic                        C,
  input logic                        R,
  v_serial_to_parallel_16_if.slave   bus
);

  typedef enum logic {IDLE, SHIFT} state_t;

  // Declaration initialisers give the power-up state equal to the reset state.
  state_t      state_q = IDLE;
  state_t      state_d;
  logic [3:0]  cnt_q   = '0;
  logic [3:0]  cnt_d;
  logic [15:0] sr_q    = '0;
  logic [15:0] sr_d;
  logic [15:0] q_q     = INIT;
  logic [15:0] q_d;
  logic        qv_q    = 1'b0;
  logic        qv_d;
  logic        ovr_q   = 1'b0;
  logic        ovr_d;

  logic [15:0] first;
  logic [15:0] shifted;
  logic        done;

  always_comb begin
    first   = (MSB_FIRST != 0) ? {15'b0, bus.SI} : {bus.SI, 15'b0};
    shifted = (MSB_FIRST != 0) ? {sr_q[14:0], bus.SI} : {bus.SI, sr_q[15:1]};

    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    done    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.SV && bus.SOF) begin
          sr_d    = first;
          cnt_d   = 4'd1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.SV) begin
          if (bus.SOF) begin
            // SOF mid-word silently restarts framing on the current bit.
            sr_d  = first;
            cnt_d = 4'd1;
          end else begin
            sr_d  = shifted;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
              done    = 1'b1;
              cnt_d   = '0;
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    q_d   = q_q;
    qv_d  = qv_q;
    ovr_d = ovr_q;
    if (done) begin
      // A word finishing while the consumer takes the old one is accepted.
      if (!qv_q || bus.QR) begin
        q_d  = shifted;
        qv_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (qv_q && bus.QR) begin
      qv_d = 1'b0;
    end
  end

  always_ff @(posedge C) begin
    if (!R) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      q_q     <= INIT;
      qv_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      q_q     <= q_d;
      qv_q    <= qv_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.Q   = q_q;
  assign bus.QV  = qv_q;
  assign bus.OVR = ovr_q;

endmodule

// File: tb/tb_v_serial_to_parallel_16.sv
// Bench for v_serial_to_parallel_16: MSB-first and LSB-first instances share
// framing/handshake stimulus, each checked against a bit-list reference model.
module tb_v_serial_to_parallel_16;

  localparam logic [15:0] INIT_V = 16'hFEDC;

  logic C;
  logic R;

  v_serial_to_parallel_16_if im ();
  v_serial_to_parallel_16_if il ();

  v_serial_to_parallel_16 #(.MSB_FIRST(1), .INIT(INIT_V)) dut_m (.C(C), .R(R), .bus(im.slave));
  v_serial_to_parallel_16 #(.MSB_FIRST(0), .INIT(INIT_V)) dut_l (.C(C), .R(R), .bus(il.slave));

  initial C = 1'b0;
  always #5 C = ~C;

  int errors = 0;
  int checks = 0;

  // Reference model: index 0 = MSB-first instance, 1 = LSB-first instance.
  logic [15:0] mq   [2];
  logic        mqv  [2];
  logic        movr [2];
  logic        busy [2];
  logic [15:0] bb   [2];
  int          nb   [2];

  typedef struct {
    logic [15:0] word;
    int          gap;
    logic        qr;
    logic [15:0] exp_q;
    logic        exp_qv;
    logic        exp_ovr;
    logic        post_qr;
    logic        exp_qv_post;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge(input int k, input logic r, input logic si, input logic sv,
                            input logic sof, input logic qr);
    logic [15:0] w;
    logic        done;
    done = 1'b0;
    w    = '0;
    if (!r) begin
      mq[k] = INIT_V; mqv[k] = 1'b0; movr[k] = 1'b0; busy[k] = 1'b0; nb[k] = 0;
      return;
    end
    if (sv && sof) begin
      bb[k] = '0; bb[k][0] = si; nb[k] = 1; busy[k] = 1'b1;
    end else if (sv && busy[k]) begin
      bb[k][nb[k]] = si;
      nb[k]++;
      if (nb[k] == 16) begin
        done = 1'b1; busy[k] = 1'b0; nb[k] = 0;
      end
    end
    if (done) begin
      for (int unsigned i = 0; i < 16; i++)
        if (k == 0) w[15-i] = bb[k][i];
        else        w[i]    = bb[k][i];
      if (!mqv[k] || qr) begin
        mq[k] = w; mqv[k] = 1'b1;
      end else begin
        movr[k] = 1'b1;
      end
    end else if (mqv[k] && qr) begin
      mqv[k] = 1'b0;
    end
  endtask

  task automatic step(input logic r, input logic si_m, input logic si_l, input logic sv,
                      input logic sof, input logic qr);
    R = r;
    im.SI = si_m; im.SV = sv; im.SOF = sof; im.QR = qr;
    il.SI = si_l; il.SV = sv; il.SOF = sof; il.QR = qr;
    @(posedge C);
    model_edge(0, r, si_m, sv, sof, qr);
    model_edge(1, r, si_l, sv, sof, qr);
    #1;
    chk("m_q",   im.Q,   mq[0]);
    chk("m_qv",  {15'b0, im.QV},  {15'b0, mqv[0]});
    chk("m_ovr", {15'b0, im.OVR}, {15'b0, movr[0]});
    chk("l_q",   il.Q,   mq[1]);
    chk("l_qv",  {15'b0, il.QV},  {15'b0, mqv[1]});
    chk("l_ovr", {15'b0, il.OVR}, {15'b0, movr[1]});
  endtask

  // Sends n bits: MSB-first order to dut_m, LSB-first order to dut_l.
  task automatic send(input logic [15:0] w, input int n, input logic sof, input int gap,
                      input logic qr, input logic r_last);
    for (int i = 0; i < n; i++) begin
      step((i == n - 1) ? r_last : 1'b1, w[15-i], w[i], 1'b1, sof && (i == 0), qr);
      if (i != n - 1)
        repeat (gap) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, qr);
    end
  endtask

  task automatic chk_both(input string nm, input logic [15:0] q, input logic qv, input logic ovr);
    chk({nm, "_m_q"},   im.Q, q);
    chk({nm, "_m_qv"},  {15'b0, im.QV},  {15'b0, qv});
    chk({nm, "_m_ovr"}, {15'b0, im.OVR}, {15'b0, ovr});
    chk({nm, "_l_q"},   il.Q, q);
    chk({nm, "_l_qv"},  {15'b0, il.QV},  {15'b0, qv});
    chk({nm, "_l_ovr"}, {15'b0, il.OVR}, {15'b0, ovr});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      mq[k] = INIT_V; mqv[k] = 1'b0; movr[k] = 1'b0; busy[k] = 1'b0; bb[k] = '0; nb[k] = 0;
    end
    vecs[0] = '{word: 16'hA5C3, gap: 0, qr: 1'b1, exp_q: 16'hA5C3, exp_qv: 1'b1, exp_ovr: 1'b0, post_qr: 1'b1, exp_qv_post: 1'b0};
    vecs[1] = '{word: 16'h1234, gap: 3, qr: 1'b0, exp_q: 16'h1234, exp_qv: 1'b1, exp_ovr: 1'b0, post_qr: 1'b0, exp_qv_post: 1'b1};
    vecs[2] = '{word: 16'h00FF, gap: 0, qr: 1'b1, exp_q: 16'h00FF, exp_qv: 1'b1, exp_ovr: 1'b0, post_qr: 1'b1, exp_qv_post: 1'b0};
    vecs[3] = '{word: 16'h1111, gap: 0, qr: 1'b0, exp_q: 16'h1111, exp_qv: 1'b1, exp_ovr: 1'b0, post_qr: 1'b0, exp_qv_post: 1'b1};
    vecs[4] = '{word: 16'h2222, gap: 0, qr: 1'b0, exp_q: 16'h1111, exp_qv: 1'b1, exp_ovr: 1'b1, post_qr: 1'b1, exp_qv_post: 1'b0};
    vecs[5] = '{word: 16'hBEEF, gap: 1, qr: 1'b1, exp_q: 16'hBEEF, exp_qv: 1'b1, exp_ovr: 1'b1, post_qr: 1'b1, exp_qv_post: 1'b0};

    R = 1'b1;
    im.SI = 1'b0; im.SV = 1'b0; im.SOF = 1'b0; im.QR = 1'b0;
    il.SI = 1'b0; il.SV = 1'b0; il.SOF = 1'b0; il.QR = 1'b0;
    #1;
    chk_both("powerup", 16'hFEDC, 1'b0, 1'b0);

    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_both("reset", 16'hFEDC, 1'b0, 1'b0);

    foreach (vecs[v]) begin
      send(vecs[v].word, 16, 1'b1, vecs[v].gap, vecs[v].qr, 1'b1);
      chk_both($sformatf("vec%0d", v), vecs[v].exp_q, vecs[v].exp_qv, vecs[v].exp_ovr);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, vecs[v].post_qr);
      chk({$sformatf("vec%0d", v), "_post_m_qv"}, {15'b0, im.QV}, {15'b0, vecs[v].exp_qv_post});
      chk({$sformatf("vec%0d", v), "_post_l_qv"}, {15'b0, il.QV}, {15'b0, vecs[v].exp_qv_post});
    end

    // Partial word abandoned by a fresh SOF.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send(16'hAAAA, 7, 1'b1, 0, 1'b0, 1'b1);
    send(16'h00FF, 16, 1'b1, 0, 1'b0, 1'b1);
    chk_both("restart", 16'h00FF, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset on the completion edge wins; bits without SOF afterwards are ignored.
    send(16'hBEEF, 16, 1'b1, 0, 1'b1, 1'b0);
    chk_both("rst_at_done", 16'hFEDC, 1'b0, 1'b0);
    send(16'h5A5A, 16, 1'b0, 0, 1'b1, 1'b1);
    chk_both("no_sof", 16'hFEDC, 1'b0, 1'b0);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++)
      step($urandom_range(0, 199) != 0, 1'($urandom), 1'($urandom),
           $urandom_range(0, 9) < 7, $urandom_range(0, 29) == 0, 1'($urandom));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
